pipeline_irq_controller: RTL

- Parametrised interrupt sequencer for the pipelined RISC core, replacing the constant-0 interrupt inputs of the fetch and decode stages.
- Latches up to N_IRQ edge-triggered requests, arbitrates them by fixed priority, and sequences the pipeline through drain, PC push and vector redirect.
- Blocks nesting until return-from-interrupt.
- Sits beside the hazard unit; its flush, stall and redirect outputs are ORed with the hazard unit's at the top level.

---
 rtl/pipeline_irq_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipeline_irq_controller.sv
// Interrupt sequencer for the pipelined core: latches rising edges on the
// request lines, picks the lowest enabled line, then walks the pipeline
// through drain, return-PC push and vector redirect. Further entries are
// blocked until the handler signals return-from-interrupt.
module pipeline_irq_controller #(
    parameter int                  N_IRQ        = 4,
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] VEC_BASE     = '0,
    parameter int                  VEC_STRIDE   = 2,
    parameter int                  DRAIN_CYCLES = 2,
    localparam int                 ID_W         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [N_IRQ-1:0]    i_irq,
    input  logic [N_IRQ-1:0]    i_irq_mask,
    input  logic                i_global_en,
    input  logic                i_branch_busy,
    input  logic                i_rti,
    input  logic [PC_WIDTH-1:0] i_pc_fetch,
    output logic                o_stall_fetch,
    output logic                o_flush_f_d,
    output logic                o_flush_d_em,
    output logic                o_push_pc,
    output logic [PC_WIDTH-1:0] o_ret_pc,
    output logic                o_pc_redirect,
    output logic [PC_WIDTH-1:0] o_pc_new,
    output logic                o_in_service,
    output logic [ID_W-1:0]     o_active_id,
    output logic [N_IRQ-1:0]    o_pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH,
        ST_VECTOR
    } state_t;

    state_t              state;
    logic [3:0]          drain_cnt;
    logic [N_IRQ-1:0]    irq_q;
    logic [N_IRQ-1:0]    irq_rise;
    logic [N_IRQ-1:0]    eligible;
    logic [N_IRQ-1:0]    clear_mask;
    logic [ID_W-1:0]     winner;
    logic                winner_valid;
    logic                take;
    logic [PC_WIDTH-1:0] vec_addr;

    assign irq_rise = i_irq & ~irq_q;
    assign eligible = o_pending & i_irq_mask;

    // Fixed-priority pick: the lowest eligible index wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        winner       = '0;
        winner_valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = ID_W'(i);
                winner_valid = 1'b1;
            end
        end
    end

    assign take = (state == ST_IDLE) && winner_valid && i_global_en &&
                  !o_in_service && !i_branch_busy;

    assign clear_mask = take ? (N_IRQ'(1) << winner) : '0;

    // Vector address in PC_WIDTH arithmetic; overflow wraps by truncation.
    assign vec_addr = VEC_BASE + PC_WIDTH'(o_active_id) * PC_WIDTH'(VEC_STRIDE);

    // Edge history and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            irq_q     <= '0;
            o_pending <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            irq_q     <= i_irq;
            o_pending <= (o_pending & ~clear_mask) | irq_rise;
        end
    end

    // Entry sequencer with registered control outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            o_stall_fetch <= 1'b0;
            o_flush_f_d   <= 1'b0;
            o_flush_d_em  <= 1'b0;
            o_push_pc     <= 1'b0;
            o_ret_pc      <= '0;
            o_pc_redirect <= 1'b0;
            o_pc_new      <= '0;
            o_in_service  <= 1'b0;
            o_active_id   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (o_in_service && i_rti) begin
                        o_in_service <= 1'b0;
                    end
                    if (take) begin
                        state         <= ST_DRAIN;
                        o_active_id   <= winner;
                        drain_cnt     <= 4'(DRAIN_CYCLES - 1);
                        o_stall_fetch <= 1'b1;
                        o_flush_f_d   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state       <= ST_PUSH;
                        o_ret_pc    <= i_pc_fetch;
                        o_flush_f_d <= 1'b0;
                        o_push_pc   <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                ST_PUSH: begin
                    state         <= ST_VECTOR;
                    o_push_pc     <= 1'b0;
                    o_stall_fetch <= 1'b0;
                    o_pc_redirect <= 1'b1;
                    o_pc_new      <= vec_addr;
                    o_flush_f_d   <= 1'b1;
                    o_flush_d_em  <= 1'b1;
                end
                ST_VECTOR: begin
                    state         <= ST_IDLE;
                    o_pc_redirect <= 1'b0;
                    o_flush_f_d   <= 1'b0;
                    o_flush_d_em  <= 1'b0;
                    o_in_service  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
